// File: rtl/sha_msg_schedule_if.sv
// Stream interface for the SHA-2 message-schedule expander.
// master: block padder / testbench side; slave: the schedule expander.
interface sha_msg_schedule_if #(
    parameter int unsigned WORD_W = 32
);
    logic              in_valid;
    logic              in_ready;
    logic [WORD_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [WORD_W-1:0] out_data;
    logic [6:0]        out_idx;
    logic              out_last;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_idx, out_last
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_idx, out_last
    );
endinterface

// File: rtl/sha_msg_schedule.sv
// SHA-2 message-schedule expander: loads 16 message words into a sliding
// window, then streams W[0..ROUNDS-1], one word per output handshake.
module sha_msg_schedule #(
    parameter int unsigned WORD_W = 32,
    parameter int unsigned ROUNDS = (WORD_W == 64) ? 80 : 64
) (
    input logic               clk,
    input logic               rst_n,
    sha_msg_schedule_if.slave bus
);

    if (!(WORD_W == 32 || WORD_W == 64)) begin : g_bad_word_w
        $error("sha_msg_schedule: WORD_W must be 32 or 64");
    end
    if (ROUNDS < 16 || ROUNDS > 128) begin : g_bad_rounds
        $error("sha_msg_schedule: ROUNDS must be in 16..128");
    end

    // Rotate/shift amounts for the two SHA-2 families.
    localparam int unsigned S0R1 = (WORD_W == 64) ? 1  : 7;
    localparam int unsigned S0R2 = (WORD_W == 64) ? 8  : 18;
    localparam int unsigned S0SH = (WORD_W == 64) ? 7  : 3;
    localparam int unsigned S1R1 = (WORD_W == 64) ? 19 : 17;
    localparam int unsigned S1R2 = (WORD_W == 64) ? 61 : 19;
    localparam int unsigned S1SH = (WORD_W == 64) ? 6  : 10;

    localparam logic [6:0] LastT = 7'(ROUNDS - 1);

    typedef enum logic {StLoad, StEmit} state_e;

    state_e            state_q, state_d;
    logic [WORD_W-1:0] win_q [16];
    logic [WORD_W-1:0] win_d [16];
    logic [3:0]        load_cnt_q, load_cnt_d;
    logic [6:0]        t_q, t_d;
    logic [WORD_W-1:0] nw;
    logic              in_hs, out_hs;

    function automatic logic [WORD_W-1:0] rotr(input logic [WORD_W-1:0] x, input int unsigned n);
        return (x >> n) | (x << (WORD_W - n));
    endfunction

    function automatic logic [WORD_W-1:0] sig0(input logic [WORD_W-1:0] x);
        return rotr(x, S0R1) ^ rotr(x, S0R2) ^ (x >> S0SH);
    endfunction

    function automatic logic [WORD_W-1:0] sig1(input logic [WORD_W-1:0] x);
        return rotr(x, S1R1) ^ rotr(x, S1R2) ^ (x >> S1SH);
    endfunction

    // Next schedule word from the window; window slot 0 holds W[t].
    always_comb begin
        nw = sig1(win_q[14]) + win_q[9] + sig0(win_q[1]) + win_q[0];
    end

    // Handshake outputs, next-state and window update.
    always_comb begin
        bus.in_ready  = rst_n & (state_q == StLoad);
        bus.out_valid = rst_n & (state_q == StEmit);
        bus.out_data  = win_q[0];
        bus.out_idx   = t_q;
        bus.out_last  = bus.out_valid & (t_q == LastT);

        in_hs  = bus.in_valid & bus.in_ready;
        out_hs = bus.out_valid & bus.out_ready;

        state_d    = state_q;
        load_cnt_d = load_cnt_q;
        t_d        = t_q;
        win_d      = win_q;

        unique case (state_q)
            StLoad: begin
                if (in_hs) begin
                    win_d[load_cnt_q] = bus.in_data;
                    load_cnt_d        = load_cnt_q + 4'd1;  // wraps to 0 after the 16th word
                    if (load_cnt_q == 4'd15) begin
                        state_d = StEmit;
                        t_d     = '0;
                    end
                end
            end
            StEmit: begin
                if (out_hs) begin
                    for (int k = 0; k < 15; k++) begin
                        win_d[k] = win_q[k+1];
                    end
                    win_d[15] = nw;
                    if (t_q == LastT) begin
                        state_d = StLoad;
                        t_d     = '0;
                    end else begin
                        t_d = t_q + 7'd1;
                    end
                end
            end
            default: state_d = StLoad;
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= StLoad;
            load_cnt_q <= '0;
            t_q        <= '0;
            win_q      <= '{default: '0};
        end else begin
            state_q    <= state_d;
            load_cnt_q <= load_cnt_d;
            t_q        <= t_d;
            win_q      <= win_d;
        end
    end

endmodule

// File: tb/tb_sha_msg_schedule.sv
// Directed bench for sha_msg_schedule: SHA-256 and SHA-512 instances.
module tb_sha_msg_schedule;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    sha_msg_schedule_if #(.WORD_W(32)) b32 ();
    sha_msg_schedule_if #(.WORD_W(64)) b64 ();

    sha_msg_schedule #(.WORD_W(32)) u32 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b32)
    );

    sha_msg_schedule #(.WORD_W(64)) u64 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b64)
    );

    int checks = 0;
    int errors = 0;

    logic [31:0] m32 [16];
    logic [31:0] e32 [64];
    logic [63:0] m64 [16];
    logic [63:0] e64 [80];
    logic [31:0] cap32_16, cap32_17;
    logic [63:0] cap64_16, cap64_17;
    int          cyc_used;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: textbook recurrence over the full W[] array.
    function automatic logic [31:0] rr32(input logic [31:0] x, input int n);
        logic [63:0] d;
        d = {x, x} >> n;
        return d[31:0];
    endfunction

    function automatic logic [63:0] rr64(input logic [63:0] x, input int n);
        logic [127:0] d;
        d = {x, x} >> n;
        return d[63:0];
    endfunction

    task automatic build32();
        for (int t = 0; t < 64; t++) begin
            if (t < 16) e32[t] = m32[t];
            else e32[t] = (rr32(e32[t-2], 17) ^ rr32(e32[t-2], 19) ^ (e32[t-2] >> 10))
                        + e32[t-7]
                        + (rr32(e32[t-15], 7) ^ rr32(e32[t-15], 18) ^ (e32[t-15] >> 3))
                        + e32[t-16];
        end
    endtask

    task automatic build64();
        for (int t = 0; t < 80; t++) begin
            if (t < 16) e64[t] = m64[t];
            else e64[t] = (rr64(e64[t-2], 19) ^ rr64(e64[t-2], 61) ^ (e64[t-2] >> 6))
                        + e64[t-7]
                        + (rr64(e64[t-15], 1) ^ rr64(e64[t-15], 8) ^ (e64[t-15] >> 7))
                        + e64[t-16];
        end
    endtask

    task automatic set_abc32();
        for (int i = 0; i < 16; i++) m32[i] = 32'h0;
        m32[0]  = 32'h6162_6380;
        m32[15] = 32'h0000_0018;
        build32();
    endtask

    // Feed 16 words; with gaps, idle cycles are inserted at random.
    task automatic load32(input bit gaps);
        for (int i = 0; i < 16; i++) begin
            if (gaps) begin
                for (int g = 0; g < 3 && $urandom_range(0, 1) == 0; g++) begin
                    b32.in_valid = 1'b0;
                    b32.in_data  = $urandom;
                    tick();
                    chk("load32_gap_state", {b32.out_valid, b32.in_ready}, {1'b0, 1'b1});
                end
            end
            chk("load32_ready", b32.in_ready, 1'b1);
            b32.in_valid = 1'b1;
            b32.in_data  = m32[i];
            tick();
        end
        b32.in_valid = 1'b0;
        chk("emit32_entry", {b32.out_valid, b32.in_ready, b32.out_idx}, {1'b1, 1'b0, 7'd0});
    endtask

    // mode 0: no stalls; 1: 5-cycle stall at t=20, random after, junk in_valid;
    // 2: stop at t=30 so the caller can reset.
    task automatic drain32(input int mode);
        int idx = 0;
        int cyc = 0;
        int stall = 0;
        bit rdy;
        while (idx < 64 && cyc < 1000) begin
            if (mode == 2 && idx == 30) break;
            rdy = 1'b1;
            if (mode == 1) begin
                if (idx == 20 && stall < 5) begin
                    rdy = 1'b0;
                    stall++;
                end else if (idx > 20 && $urandom_range(0, 2) == 0) begin
                    rdy = 1'b0;
                end
                b32.in_valid = (idx < 63);
                b32.in_data  = 32'hDEAD_BEEF;
            end
            b32.out_ready = rdy;
            chk("emit32", {b32.out_valid, b32.out_last, b32.in_ready, b32.out_idx, b32.out_data},
                {1'b1, (idx == 63), 1'b0, 7'(idx), e32[idx]});
            if (idx == 16) cap32_16 = b32.out_data;
            if (idx == 17) cap32_17 = b32.out_data;
            tick();
            if (rdy) idx++;
            cyc++;
        end
        b32.in_valid = 1'b0;
        cyc_used = cyc;
        if (mode != 2) begin
            chk("drain32_done", {b32.out_valid, b32.in_ready, 7'(idx)}, {1'b0, 1'b1, 7'd64});
        end
    endtask

    initial begin
        rst_n         = 1'b0;
        b32.in_valid  = 1'b0;
        b32.in_data   = '0;
        b32.out_ready = 1'b0;
        b64.in_valid  = 1'b0;
        b64.in_data   = '0;
        b64.out_ready = 1'b0;
        tick();
        tick();

        // Reset state, still held in reset.
        chk("rst32_outputs", {b32.in_ready, b32.out_valid, b32.out_last, b32.out_idx, b32.out_data},
            '0);
        chk("rst64_outputs", {b64.in_ready, b64.out_valid, b64.out_last, b64.out_idx, b64.out_data},
            '0);
        rst_n = 1'b1;
        #1;
        chk("rst_release", {b32.in_ready, b32.out_valid, b64.in_ready, b64.out_valid},
            {1'b1, 1'b0, 1'b1, 1'b0});

        // SHA-256 "abc" block, no stalls.
        set_abc32();
        load32(1'b0);
        drain32(0);
        chk("abc32_w16", cap32_16, 32'h6162_6380);
        chk("abc32_w17", cap32_17, 32'h000F_0000);
        chk("abc32_cycles", 32'(cyc_used), 32'd64);

        // sigma0 only: W16 = sigma0(0x0000FFFF); W17 picks up W1 via the t-16 term.
        for (int i = 0; i < 16; i++) m32[i] = 32'h0;
        m32[1] = 32'h0000_FFFF;
        build32();
        load32(1'b0);
        drain32(0);
        chk("sig0_w16", cap32_16, 32'hC1FF_DE00);
        chk("sig0_w17", cap32_17, 32'h0000_FFFF);

        // Backpressure with junk on the input side during EMIT.
        set_abc32();
        load32(1'b0);
        drain32(1);

        // Gappy input stream.
        load32(1'b1);
        drain32(0);
        chk("gaps_w16", cap32_16, 32'h6162_6380);

        // Reset in the middle of EMIT.
        load32(1'b0);
        drain32(2);
        rst_n = 1'b0;
        #1;
        chk("midrst_held", {b32.in_ready, b32.out_valid}, {1'b0, 1'b0});
        tick();
        rst_n = 1'b1;
        #1;
        chk("midrst_after", {b32.out_valid, b32.in_ready, b32.out_idx, b32.out_data},
            {1'b0, 1'b1, 7'd0, 32'h0});
        load32(1'b0);
        drain32(0);
        chk("midrst_w16", cap32_16, 32'h6162_6380);

        // SHA-512 instance, "abc" block.
        for (int i = 0; i < 16; i++) m64[i] = 64'h0;
        m64[0]  = 64'h6162_6380_0000_0000;
        m64[15] = 64'h0000_0000_0000_0018;
        build64();
        b64.out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            b64.in_valid = 1'b1;
            b64.in_data  = m64[i];
            tick();
        end
        b64.in_valid = 1'b0;
        chk("emit64_entry", {b64.out_valid, b64.in_ready, b64.out_idx}, {1'b1, 1'b0, 7'd0});
        begin
            int idx = 0;
            int cyc = 0;
            while (idx < 80 && cyc < 1000) begin
                chk("emit64", {b64.out_valid, b64.out_last, b64.out_idx, b64.out_data},
                    {1'b1, (idx == 79), 7'(idx), e64[idx]});
                if (idx == 16) cap64_16 = b64.out_data;
                if (idx == 17) cap64_17 = b64.out_data;
                tick();
                idx++;
                cyc++;
            end
            chk("drain64_done", {b64.out_valid, b64.in_ready, 7'(idx)}, {1'b0, 1'b1, 7'd80});
        end
        // sigma1(0x18) = ROTR19 -> bits 48,49; ROTR61 -> bits 6,7.
        chk("abc64_w16", cap64_16, 64'h6162_6380_0000_0000);
        chk("abc64_w17", cap64_17, 64'h0003_0000_0000_00C0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
